icache_controller: RTL and testbench
====================================

Name: icache_controller

Overview:
- Direct-mapped instruction cache and refill controller between CPU fetch stage and the 16-byte-block instruction memory (6-bit block address, read/busywait handshake, 128-bit block readdata).
- Serves 32-bit instruction reads on hit with zero stall; on miss sequences one block refill from instruction memory, installs it, then serves the fetch.
- Keeps saturating hit/miss counters for performance bring-up.

Parameters:
- ADDR_W, 10, CPU byte-address width (1024-byte instruction space).
- LINES, 8, number of cache lines; power of two, 2..32.
- CNT_W, 16, width of hit/miss counters.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- address  input  ADDR_W  CPU instruction byte address (PC); bits[1:0] ignored.
- read  input  1  CPU fetch request; level-held until busywait low.
- instruction  output  32  selected instruction word.
- busywait  output  1  CPU stall.
- mem_read  output  1  refill request to instruction memory.
- mem_address  output  6  block address to instruction memory.
- mem_readdata  input  128  refill block; byte k at bits[8k+7:8k].
- mem_busywait  input  1  instruction memory busy.
- hit_count  output  CNT_W  saturating count of hits.
- miss_count  output  CNT_W  saturating count of misses.

Behaviour:
- Address split: offset = address[3:2] (word in block), index = address[3+log2(LINES):4], tag = address[ADDR_W-1:4+log2(LINES)] (3 bits at defaults).
- Per line: valid bit, tag, 128-bit data.
- instruction = data[index] word offset, combinational; word 0 = bits[31:0], word 3 = bits[127:96]; don't-care when not hit.
- hit = read & valid[index] & (tag_store[index] == tag), combinational.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE: busywait = read & !hit.
  - On posedge, if read & !hit: latch {tag,index} into miss register, increment miss_count, go MEM_READ.
  - If read & hit: increment hit_count, stay IDLE.
- MEM_READ:
  - mem_read = 1; mem_address = latched {tag,index}; busywait = 1.
  - Stay while mem_busywait = 1.
  - On a posedge with mem_busywait = 0 (after at least one cycle in state), go UPDATE.
  - mem_read drops as the state is left.
- UPDATE:
  - busywait = 1; mem_read = 0.
  - At posedge write mem_readdata into the latched line, set valid, write tag, return IDLE.
  - The fetch then re-evaluates as a hit: exactly one hit is counted on the following cycle.
- Minimum miss penalty: MEM_READ cycles + 1 UPDATE cycle + 1 IDLE hit cycle.
- read = 0: busywait = 0 in IDLE; no counter change. A refill already in flight still completes.
- CPU address changes during refill: the refill completes for the latched address. IDLE then evaluates the new address, which may miss again.
- Counters saturate at all-ones; no wrap.
- Reset (async, low), including mid-refill:
  - all valid bits cleared; state to IDLE; mem_read = 0; busywait = 0 (if read low); counters = 0; miss register = 0.
  - Data/tag arrays are not cleared.
  - After release, a pending read misses and restarts the refill cleanly.
- mem_address held stable for the whole MEM_READ state.
- No self-modifying code support: no write port, no invalidate.

Decomposition:
- Shared package:
  - state encoding (IDLE/MEM_READ/UPDATE);
  - BLOCK_BYTES = 16, WORD_BYTES = 4, MEM_ADDR_W = 6;
  - derived INDEX_W / TAG_W functions.
- One sub-module, icache_line_store: valid/tag/data arrays with async valid clear, single write port, combinational read of the indexed line. The controller keeps the FSM, miss register and counters.

Test Plan (memory model preloaded: word@0 = 0x00040019, @4 = 0x00050023, @8 = 0x02060405, @128 = 0x0000005A):
- Cold read address 0:
  - busywait = 1 same cycle; mem_read = 1 next cycle with mem_address = 0.
  - After memory clears busywait: UPDATE, then instruction = 0x00040019 with busywait = 0.
  - miss_count = 1, hit_count = 1.
- Address 4, then 8, after the line-0 fill:
  - busywait stays 0; instruction = 0x00050023, then 0x02060405.
  - hit_count increments 1 per cycle; mem_read never asserts.
- Conflict, address 128 (index 0, tag 1):
  - mem_read with mem_address = 8; line 0 replaced; instruction = 0x0000005A.
  - Re-read address 0 misses again (miss_count + 1).
- Reset pulsed low during MEM_READ:
  - mem_read = 0 and state IDLE immediately; counters = 0.
  - Read address 0 after release misses and refills correctly.
- read = 0 for 5 cycles in IDLE: busywait = 0, counters unchanged, mem_read = 0.
- Force CNT_W = 2: four hits → hit_count stays 3 after the third hit.

Source files
------------

// File: rtl/icache_controller_pkg.sv
// rtl/icache_controller_pkg.sv - shared FSM encoding, geometry constants and width helpers
// Purpose : common definitions for the instruction cache controller and its line store.
// Contents: state_e (IDLE/MEM_READ/UPDATE), block/word geometry, index/tag width functions.
package icache_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

  localparam int BLOCK_BYTES = 16;
  localparam int WORD_BYTES  = 4;
  localparam int MEM_ADDR_W  = 6;
  localparam int BLOCK_BITS  = BLOCK_BYTES * 8;
  localparam int OFFSET_LSB  = $clog2(WORD_BYTES);
  localparam int INDEX_LSB   = $clog2(BLOCK_BYTES);

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - INDEX_LSB - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - valid/tag/data arrays for the direct-mapped instruction cache
// Purpose : per-line storage with one write port and a combinational read of the indexed line.
// Ports   : clock_i, reset_ni (async, active-low; clears valid bits only),
//           rd_index_i -> rd_valid_o / rd_tag_o / rd_data_o,
//           wr_en_i, wr_index_i, wr_tag_i, wr_data_i (installs a line and marks it valid).
module icache_line_store
  import icache_controller_pkg::*;
#(
  parameter int LINES = 8,
  parameter int TAG_W = 3
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic [$clog2(LINES)-1:0]  rd_index_i,
  output logic                      rd_valid_o,
  output logic [TAG_W-1:0]          rd_tag_o,
  output logic [BLOCK_BITS-1:0]     rd_data_o,
  input  logic                      wr_en_i,
  input  logic [$clog2(LINES)-1:0]  wr_index_i,
  input  logic [TAG_W-1:0]          wr_tag_i,
  input  logic [BLOCK_BITS-1:0]     wr_data_i
);

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [BLOCK_BITS-1:0] data_q [LINES];

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while the valid bit is clear,
  // so they are left out of reset.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_controller.sv
// rtl/icache_controller.sv - direct-mapped instruction cache with single-block refill FSM
// Purpose : serves 32-bit fetches on hit with no stall; on miss refills one 16-byte block.
// Ports   : clock_i, reset_ni (async, active-low),
//           CPU side  : address_i, read_i, instruction_o, busywait_o,
//           memory    : mem_read_o, mem_address_o, mem_readdata_i, mem_busywait_i,
//           counters  : hit_count_o, miss_count_o (saturating).
module icache_controller
  import icache_controller_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LINES  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic [ADDR_W-1:0]      address_i,
  input  logic                   read_i,
  output logic [31:0]            instruction_o,
  output logic                   busywait_o,
  output logic                   mem_read_o,
  output logic [MEM_ADDR_W-1:0]  mem_address_o,
  input  logic [BLOCK_BITS-1:0]  mem_readdata_i,
  input  logic                   mem_busywait_i,
  output logic [CNT_W-1:0]       hit_count_o,
  output logic [CNT_W-1:0]       miss_count_o
);

  localparam int IDX_W = index_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);
  localparam int BLK_W = ADDR_W - INDEX_LSB;

  logic [1:0]       offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             unused_byte_bits;

  assign offset           = address_i[INDEX_LSB-1:OFFSET_LSB];
  assign index            = address_i[INDEX_LSB +: IDX_W];
  assign tag              = address_i[ADDR_W-1 -: TAG_W];
  assign unused_byte_bits = ^address_i[OFFSET_LSB-1:0];

  state_e           state_q, state_d;
  logic [BLK_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] hit_q, miss_cnt_q;
  logic             hit_inc, miss_inc, line_we;

  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [BLOCK_BITS-1:0] line_data;
  logic                  hit;

  icache_line_store #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_line_store (
    .clock_i    (clock_i),
    .reset_ni   (reset_ni),
    .rd_index_i (index),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (line_we),
    .wr_index_i (miss_q[IDX_W-1:0]),
    .wr_tag_i   (miss_q[BLK_W-1:IDX_W]),
    .wr_data_i  (mem_readdata_i)
  );

  assign hit           = read_i & line_valid & (line_tag == tag);
  assign instruction_o = line_data[{offset, 5'b0} +: 32];
  // The miss register holds {tag,index}, which is exactly the block address.
  assign mem_address_o = MEM_ADDR_W'(miss_q);
  assign hit_count_o   = hit_q;
  assign miss_count_o  = miss_cnt_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      miss_q     <= '0;
      hit_q      <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      if (hit_inc && (hit_q != '1)) begin
        hit_q <= hit_q + 1'b1;
      end
      if (miss_inc && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    miss_d     = miss_q;
    busywait_o = 1'b0;
    mem_read_o = 1'b0;
    line_we    = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busywait_o = read_i & ~hit;
        if (read_i && !hit) begin
          miss_d   = {tag, index};
          miss_inc = 1'b1;
          state_d  = ST_MEM_READ;
        end else if (hit) begin
          hit_inc = 1'b1;
        end
      end
      ST_MEM_READ: begin
        mem_read_o = 1'b1;
        busywait_o = 1'b1;
        if (!mem_busywait_i) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // Install the block; the fetch is re-evaluated as a hit back in IDLE.
        busywait_o = 1'b1;
        line_we    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_controller.sv
// tb/tb_icache_controller.sv - directed scoreboard bench for icache_controller
// Purpose : drives fetches against a latency-modelled instruction memory and checks results.
// Ports   : none (top-level bench); instantiates a default DUT and a CNT_W=2 DUT on shared inputs.
module tb_icache_controller;

  localparam int MEM_LAT = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [9:0]   address = '0;
  logic         read = 1'b0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait;
  logic [15:0]  hit_count, miss_count;

  logic [31:0]  instruction2;
  logic         busywait2, mem_read2;
  logic [5:0]   mem_address2;
  logic [1:0]   hit_count2, miss_count2;

  logic [127:0] mem [64];
  int           mem_cnt = 0;
  logic         mem_ready = 1'b0;

  logic [31:0]  sb_q [$];
  int           n_vec = 0;
  int           n_fail = 0;
  int           exp_hits = 0;
  int           exp_misses = 0;

  always #5 clock = ~clock;

  icache_controller dut (
    .clock_i        (clock),
    .reset_ni       (reset_n),
    .address_i      (address),
    .read_i         (read),
    .instruction_o  (instruction),
    .busywait_o     (busywait),
    .mem_read_o     (mem_read),
    .mem_address_o  (mem_address),
    .mem_readdata_i (mem_readdata),
    .mem_busywait_i (mem_busywait),
    .hit_count_o    (hit_count),
    .miss_count_o   (miss_count)
  );

  icache_controller #(.CNT_W(2)) dut_sat (
    .clock_i        (clock),
    .reset_ni       (reset_n),
    .address_i      (address),
    .read_i         (read),
    .instruction_o  (instruction2),
    .busywait_o     (busywait2),
    .mem_read_o     (mem_read2),
    .mem_address_o  (mem_address2),
    .mem_readdata_i (mem_readdata),
    .mem_busywait_i (mem_busywait),
    .hit_count_o    (hit_count2),
    .miss_count_o   (miss_count2)
  );

  // Instruction memory: busy for MEM_LAT edges after a request, then holds the block.
  assign mem_busywait = mem_read && !mem_ready;

  always @(posedge clock) begin
    if (!mem_read) begin
      mem_cnt   <= 0;
      mem_ready <= 1'b0;
    end else if (!mem_ready) begin
      if (mem_cnt == MEM_LAT - 1) begin
        mem_ready    <= 1'b1;
        mem_readdata <= mem[mem_address];
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_hits"}, 32'(hit_count), 32'(exp_hits));
    check({tag, "_misses"}, 32'(miss_count), 32'(exp_misses));
    check({tag, "_hits_sat"}, 32'(hit_count2), (exp_hits > 3) ? 32'd3 : 32'(exp_hits));
    check({tag, "_misses_sat"}, 32'(miss_count2), (exp_misses > 3) ? 32'd3 : 32'(exp_misses));
  endtask

  task automatic fetch(input logic [9:0] a, input bit exp_miss, input string tag);
    logic [31:0] blk_word;
    int budget;
    @(negedge clock);
    address = a;
    read    = 1'b1;
    blk_word = mem[a[9:4]][{a[3:2], 5'b0} +: 32];
    sb_q.push_back(blk_word);
    #1;
    check({tag, "_stall"}, 32'(busywait), 32'(exp_miss));
    if (exp_miss) begin
      exp_misses++;
      @(posedge clock);
      #1;
      check({tag, "_mem_read"}, 32'(mem_read), 32'd1);
      check({tag, "_mem_addr"}, 32'(mem_address), 32'(a[9:4]));
      budget = 0;
      while (busywait !== 1'b0 && budget < 40) begin
        @(negedge clock);
        #1;
        budget++;
      end
      check({tag, "_refill_done"}, 32'(busywait), 32'd0);
    end else begin
      check({tag, "_no_mem_read"}, 32'(mem_read), 32'd0);
    end
    check({tag, "_instr"}, instruction, sb_q.pop_front());
    exp_hits++;
    @(posedge clock);
    #1;
    check_counts(tag);
  endtask

  initial begin
    for (int b = 0; b < 64; b++) begin
      for (int w = 0; w < 4; w++) begin
        mem[b][w*32 +: 32] = 32'hA000_0000 | (b << 8) | w;
      end
    end
    mem[0][31:0]  = 32'h0004_0019;
    mem[0][63:32] = 32'h0005_0023;
    mem[0][95:64] = 32'h0206_0405;
    mem[8][31:0]  = 32'h0000_005A;

    // Reset state
    #12;
    check("rst_busywait", 32'(busywait), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check_counts("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Cold miss, then hits in the same block
    fetch(10'd0, 1'b1, "cold0");
    check("cold0_word", instruction, 32'h0004_0019);
    fetch(10'd4, 1'b0, "hit4");
    check("hit4_word", instruction, 32'h0005_0023);
    fetch(10'd8, 1'b0, "hit8");
    check("hit8_word", instruction, 32'h0206_0405);

    // Conflict on line 0, then the original block misses again
    fetch(10'd128, 1'b1, "conf128");
    check("conf128_word", instruction, 32'h0000_005A);
    fetch(10'd0, 1'b1, "remiss0");
    fetch(10'd4, 1'b0, "rehit4");

    // Idle with read low
    @(negedge clock);
    read = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("idle_busywait", 32'(busywait), 32'd0);
      check("idle_mem_read", 32'(mem_read), 32'd0);
    end
    check_counts("idle");

    // Reset in the middle of a refill
    @(negedge clock);
    address = 10'h020;
    read    = 1'b1;
    @(posedge clock);
    #1;
    check("mid_mem_read", 32'(mem_read), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    exp_hits   = 0;
    exp_misses = 0;
    check("mid_rst_mem_read", 32'(mem_read), 32'd0);
    check("mid_rst_pending_stall", 32'(busywait), 32'd1);
    check_counts("mid_rst");
    read = 1'b0;
    #1;
    check("mid_rst_busywait", 32'(busywait), 32'd0);
    @(posedge clock);
    #1;
    check("mid_rst_hold_mem_read", 32'(mem_read), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Restart from a cold cache; the narrow counter saturates at 3
    fetch(10'd0, 1'b1, "post0");
    check("post0_word", instruction, 32'h0004_0019);
    fetch(10'd4, 1'b0, "post4");
    fetch(10'd8, 1'b0, "post8");
    fetch(10'd12, 1'b0, "post12");
    check("sat_hold", 32'(hit_count2), 32'd3);
    check("wide_hits", 32'(hit_count), 32'd4);

    @(negedge clock);
    read = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
